gpr_snapshot_streamer: RTL

- Consumer side of the register file's architectural-state debug outputs.
- On each instruction-commit pulse, captures the commit PC and all 32 GPR values into an internal snapshot buffer.
- Streams the snapshot as 33 beats over a valid/ready handshake to the difftest checker: PC first, then GPR 0..31.
- Sits between the CPU core (commit signal plus flattened GPR debug bus) and the difftest bridge.

---
 rtl/gpr_snapshot_streamer_pkg.sv | 17 +
 rtl/gpr_snapshot_streamer.sv | 86 ++++++++
 2 files changed

// File: rtl/gpr_snapshot_streamer_pkg.sv
// Shared constants and state encoding for the GPR snapshot streamer.
// The width constants match the register file's debug outputs.
package gpr_snapshot_streamer_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned BEATS      = REG_NUM + 1;
  localparam int unsigned IDX_W      = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = 6'd32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/gpr_snapshot_streamer.sv
// Captures commit PC plus all GPRs on a commit pulse, then streams them
// as 33 valid/ready beats (PC, GPR0..GPR31) to the difftest checker.
module gpr_snapshot_streamer
  import gpr_snapshot_streamer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          commit_valid,
  input  logic [DATA_WIDTH-1:0]         commit_pc,
  input  logic [REG_NUM*DATA_WIDTH-1:0] gpr_flat,
  output logic                          commit_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          overflow
);

  state_t                state;
  logic [DATA_WIDTH-1:0] snap [BEATS];
  logic                  capture;
  logic [IDX_W-1:0]      next_idx;

  assign capture  = (state == IDLE) && commit_valid;
  assign next_idx = out_idx + IDX_W'(1);

  // Snapshot buffer: written only on an accepted commit; GPR0 is forced to zero.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap[0] <= commit_pc;
      for (int i = 0; i < int'(REG_NUM); i++) begin
        snap[i+1] <= (i == 0) ? '0 : gpr_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // out_idx doubles as the beat counter, so the presented beat is always buffer[out_idx].
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      commit_ready <= 1'b1;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      out_last     <= 1'b0;
      out_data     <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (commit_valid) begin
            state        <= SEND;
            commit_ready <= 1'b0;
            out_valid    <= 1'b1;
            out_idx      <= '0;
            out_last     <= 1'b0;
            out_data     <= commit_pc;
          end
        end
        SEND: begin
          if (commit_valid) begin
            overflow <= 1'b1;
          end
          if (out_ready) begin
            if (out_last) begin
              state        <= IDLE;
              commit_ready <= 1'b1;
              out_valid    <= 1'b0;
              out_last     <= 1'b0;
            end else begin
              out_idx  <= next_idx;
              out_data <= snap[next_idx];
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state        <= IDLE;
          commit_ready <= 1'b1;
          out_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule
